serial_tx: RTL and testbench
============================

// Module: serial_tx
// PURPOSE
// - Parallel-in, serial-out frame transmitter: accepts a DATA_W-bit word on a valid/ready handshake and drives it on one serial line.
// - Frame format: start bit (0), data LSB first, optional even parity, stop bit (1).
// - Serves as the driving end of a serial capture path. It replaces free-running toggle stimulus with framed, rate-controlled data.
// PARAMETERS
// - DATA_W        default 8   bits per data word (>=1)
// - CLKS_PER_BIT  default 4   clk cycles each serial bit is held (>=1)
// PORTS
// - clk        in   1       single clock; all logic on posedge
// - reset      in   1       synchronous, active-low reset
// - din        in   DATA_W  parallel word to send
// - din_valid  in   1       din holds a word to send
// - din_ready  out  1       transmitter can accept a word this cycle
// - dout       out  1       serial line; idles high
// - busy       out  1       a frame is in progress
// BEHAVIOUR
// - Reset (reset==0 at posedge): state=IDLE, dout=1, din_ready=1, busy=0. Bit counter and divider counter clear to 0.
// - Reset mid-frame aborts the frame. The next cycle shows dout=1 and the partial frame is discarded.
// - All outputs are registered or decoded from state only. din_ready = (state==IDLE). busy = !din_ready.
// - Accept: din_valid && din_ready at a posedge. din is copied into the shift register. Changes on din after acceptance are ignored.
// - Latency: dout falls to 0 on the posedge that accepts the word.
// - FSM states: IDLE, START, DATA, PARITY, STOP.
// - IDLE -> START on accept.
// - START: dout=0 for CLKS_PER_BIT cycles, then -> DATA.
// - DATA: dout=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After DATA_W bits -> PARITY (if enabled) or STOP.
// - PARITY: dout = ^word for CLKS_PER_BIT cycles, then -> STOP.
// - STOP: dout=1 for CLKS_PER_BIT cycles, then -> IDLE.
// - Divider counter: $clog2(CLKS_PER_BIT)+1 bits. Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
// - CLKS_PER_BIT==1: every bit lasts exactly one cycle. No extra cycles are inserted.
// - Bit counter: $clog2(DATA_W)+1 bits. Reaches DATA_W-1 on the last data bit, then clears.
// - Frame length: (DATA_W+2)*CLKS_PER_BIT cycles, or (DATA_W+3)*CLKS_PER_BIT with parity.
// - Back-to-back frames: after STOP there is one IDLE cycle with dout=1 and din_ready=1. With din_valid held high, the next start bit begins on that cycle's posedge.
// - din_valid while busy: no effect. The word is not consumed and din_ready stays 0.
// - din_valid deasserted before acceptance: no frame is sent and the line stays 1.
// CONFIGURATION
// - Macro SERIAL_TX_PARITY_EN
// - Defined: the PARITY state is present. An even parity bit (XOR of the accepted word) is sent after the data bits.
// - Undefined: the PARITY state and its logic are compiled out. DATA -> STOP directly.
// TESTING (DATA_W=8, CLKS_PER_BIT=4)
// - Reset: hold reset=0 for 3 cycles -> dout=1, din_ready=1, busy=0. Also holds with din_valid=1 during reset.
// - Single frame: din=8'hA5, one-cycle valid -> dout 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. busy=1 for 40 cycles, then din_ready=1.
// - Back-to-back: din=8'h00 then 8'hFF, valid held high -> two 40-cycle frames separated by exactly 1 idle cycle of dout=1. The second frame's data bits are all 1.
// - Parity (SERIAL_TX_PARITY_EN): 8'hA5 -> parity bit 0 and frame 44 cycles. 8'h01 -> parity bit 1.
// - Mid-frame reset: reset=0 during data bit 3 of 8'h3C -> next cycle dout=1, din_ready=1. A new 8'h81 frame then transmits correctly.
// - Ignored input: change din and pulse din_valid while busy -> the serial output matches the original word and no extra frame is sent.

Source files
------------

// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, DATA_W data bits LSB first, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even parity bit between the data and stop bits.
module serial_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              dout,
    output logic              busy
);

    localparam int unsigned DivW = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned BitW = $clog2(DATA_W) + 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef SERIAL_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              bit_end;

`ifdef SERIAL_TX_PARITY_EN
    logic par_q, par_d;
`endif

    assign bit_end = (div_q == DivLast);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        // The divider free-runs in every non-idle state and wraps on each bit boundary.
        if (state_q != StIdle) begin
            div_d = bit_end ? '0 : div_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (din_valid) begin
                    state_d = StStart;
                    div_d   = '0;
                    bit_d   = '0;
                    shift_d = din;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = ^din;
`endif
                end
            end
            StStart: begin
                if (bit_end) state_d = StData;
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BitLast) begin
                        bit_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            StParity: begin
                if (bit_end) state_d = StStop;
            end
`endif
            StStop: begin
                if (bit_end) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level is decoded purely from registered state, so it moves on the accepting edge.
    always_comb begin
        dout = 1'b1;
        unique case (state_q)
            StStart:  dout = 1'b0;
            StData:   dout = shift_q[0];
`ifdef SERIAL_TX_PARITY_EN
            StParity: dout = par_q;
`endif
            default:  dout = 1'b1;
        endcase
    end

    assign din_ready = (state_q == StIdle);
    assign busy      = ~din_ready;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: every accepted word pushes its expected per-cycle line
// levels to a queue, and a negedge monitor pops and checks dout/din_ready/busy each cycle.
module tb_serial_tx;

    localparam int unsigned DW  = 8;
    localparam int unsigned CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int unsigned FRAME = (DW + 3) * CPB;
`else
    localparam int unsigned FRAME = (DW + 2) * CPB;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic          dout;
    logic          busy;

    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    logic exp_q[$];
    logic exp_dout;
    logic exp_rdy;

    serial_tx #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .dout     (dout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Expected line level for every cycle of one frame, starting on the accepting edge.
    function automatic void push_frame(input logic [DW-1:0] w);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < int'(DW); i++) bits.push_back(w[i]);
`ifdef SERIAL_TX_PARITY_EN
        bits.push_back(^w);
`endif
        bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int c = 0; c < int'(CPB); c++) exp_q.push_back(bits[i]);
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                exp_dout = exp_q.pop_front();
                exp_rdy  = 1'b0;
            end else begin
                exp_dout = 1'b1;
                exp_rdy  = 1'b1;
            end
            check("dout", dout, exp_dout);
            check("din_ready", din_ready, exp_rdy);
            check("busy", busy, ~exp_rdy);
        end
    end

    // Called just after a posedge while the DUT is idle; returns just after the accepting edge.
    task automatic send(input logic [DW-1:0] w);
        din       = w;
        din_valid = 1'b1;
        @(posedge clk);
        push_frame(w);
        #1;
        din_valid = 1'b0;
        din       = DW'($urandom);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with din_valid asserted must not start a frame.
        din       = 8'h5A;
        din_valid = 1'b1;
        reset     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", dout, 1'b1);
        check("reset_ready", din_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        din_valid = 1'b0;
        reset     = 1'b1;
        mon_en    = 1'b1;
        wait_cycles(3);

        // Single frame of A5 with a one-cycle valid pulse.
        send(8'hA5);
        wait_cycles(FRAME + 2);

        // Back-to-back: valid held high across two frames, one idle cycle between.
        din       = 8'h00;
        din_valid = 1'b1;
        @(posedge clk);
        push_frame(8'h00);
        #1 din = 8'hFF;
        repeat (FRAME + 1) @(posedge clk);
        push_frame(8'hFF);
        #1 din_valid = 1'b0;
        wait_cycles(FRAME + 2);

        // Parity check words (parity bit only present when the feature is built in).
        send(8'h01);
        wait_cycles(FRAME + 2);

        // Mid-frame reset during data bit 3 of 3C.
        send(8'h3C);
        wait_cycles(CPB * 4 + 1);
        mon_en = 1'b0;
        reset  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        check("abort_dout", dout, 1'b1);
        check("abort_ready", din_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        mon_en = 1'b1;
        wait_cycles(3);
        send(8'h81);
        wait_cycles(FRAME + 2);

        // Input changes and a valid pulse while busy must be ignored.
        send(8'hC3);
        wait_cycles(8);
        din       = 8'h5A;
        din_valid = 1'b1;
        wait_cycles(3);
        din_valid = 1'b0;
        wait_cycles(FRAME + 4);

        // Valid never asserted long enough to be seen: line stays idle.
        wait_cycles(5);
        mon_en = 1'b0;
        check("queue_drained", exp_q.size() == 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
